// File: rtl/pkt_mem_chan.sv
`default_nettype none
// ============================================================================
// Module   : pkt_mem_chan
// Brief    : Channel-sliced packet-buffer memory with fixed read latency and
//            a credit-protected show-ahead read-response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_mem_chan #(
    parameter  int DWIDTH     = 520,
    parameter  int CH_WIDTH   = 72,
    parameter  int AWIDTH     = 12,
    parameter  int RD_LAT     = 12,
    parameter  int FIFO_DEPTH = 16,
    localparam int c_NCH      = (DWIDTH + CH_WIDTH - 1) / CH_WIDTH,
    localparam int c_CRW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [AWIDTH-1:0] wraddress,
    input  logic [DWIDTH-1:0] wrdata,
    input  logic [c_NCH-1:0]  wr_chmask,
    input  logic              rden,
    input  logic [AWIDTH-1:0] rdaddress,
    output logic              rd_req_ready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rddata,
    output logic [c_CRW-1:0]  credits,
    output logic              err_rd_drop
);

    localparam int c_PW    = $clog2(FIFO_DEPTH);
    localparam int c_TOP_W = DWIDTH - (c_NCH - 1) * CH_WIDTH;

    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    logic [DWIDTH-1:0] w_rd_word;
    logic [DWIDTH-1:0] w_pipe_out;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [c_PW:0]     r_wr_ptr;
    logic [c_PW:0]     r_rd_ptr;
    logic [c_CRW-1:0]  r_credits;
    logic              r_err;
    logic [DWIDTH-1:0] r_fifo [FIFO_DEPTH];

    assign rd_req_ready = (r_credits != '0);
    assign w_accept     = rden & rd_req_ready;
    assign rd_valid     = (r_wr_ptr != r_rd_ptr);
    assign w_pop        = rd_valid & rd_ready;
    assign w_push       = r_vld_pipe[RD_LAT-1];

    // Zero padding of the top channel is constant and discarded on read, so
    // only the DWIDTH-covered bits of that channel are physically kept.
    generate
        for (genvar c = 0; c < c_NCH; c++) begin : g_ch
            localparam int c_W = (c == c_NCH - 1) ? c_TOP_W : CH_WIDTH;
            logic [c_W-1:0] r_mem [2**AWIDTH];
            logic [c_W-1:0] r_rd;

            always_ff @(posedge clk) begin
                if (wren && wr_chmask[c]) begin
                    r_mem[wraddress] <= wrdata[c*CH_WIDTH +: c_W];
                end
                if (w_accept) begin
                    r_rd <= r_mem[rdaddress];
                end
            end

            assign w_rd_word[c*CH_WIDTH +: c_W] = r_rd;
        end
    endgenerate

    // Read register is stage 0; the remaining RD_LAT-1 stages free-run and
    // stay aligned with the valid tokens below.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign w_pipe_out = w_rd_word;
        end else begin : g_latn
            logic [DWIDTH-1:0] r_dly [RD_LAT-1];

            always_ff @(posedge clk) begin
                r_dly[0] <= w_rd_word;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end

            assign w_pipe_out = r_dly[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    // Credits guarantee a free slot for every token, so push is unconditional.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PW-1:0]] <= w_pipe_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_credits <= c_CRW'(FIFO_DEPTH);
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (c_PW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_PW + 1)'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - c_CRW'(1);
                2'b01:   r_credits <= r_credits + c_CRW'(1);
                default: r_credits <= r_credits;
            endcase
            if (rden && !rd_req_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rddata      = rd_valid ? r_fifo[r_rd_ptr[c_PW-1:0]] : '0;
    assign credits     = r_credits;
    assign err_rd_drop = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pkt_mem_chan.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_mem_chan
// Brief    : Self-checking bench for pkt_mem_chan against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_mem_chan;

    localparam int DW  = 520;
    localparam int CW  = 72;
    localparam int AW  = 12;
    localparam int LAT = 12;
    localparam int FD  = 16;
    localparam int NCH = 8;
    localparam int CRW = 5;

    logic           clk;
    logic           rst;
    logic           wren;
    logic [AW-1:0]  wraddress;
    logic [DW-1:0]  wrdata;
    logic [NCH-1:0] wr_chmask;
    logic           rden;
    logic [AW-1:0]  rdaddress;
    logic           rd_req_ready;
    logic           rd_valid;
    logic           rd_ready;
    logic [DW-1:0]  rddata;
    logic [CRW-1:0] credits;
    logic           err_rd_drop;

    pkt_mem_chan #(
        .DWIDTH     (DW),
        .CH_WIDTH   (CW),
        .AWIDTH     (AW),
        .RD_LAT     (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wren         (wren),
        .wraddress    (wraddress),
        .wrdata       (wrdata),
        .wr_chmask    (wr_chmask),
        .rden         (rden),
        .rdaddress    (rdaddress),
        .rd_req_ready (rd_req_ready),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rddata       (rddata),
        .credits      (credits),
        .err_rd_drop  (err_rd_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural model: memory image, ordered response queue with the
    // cycle each response becomes visible, and a sticky drop flag.
    logic [DW-1:0] mem_m [0:(1<<AW)-1];
    logic [DW-1:0] q_data [$];
    int            q_time [$];
    bit            err_m;
    int            cyc;
    int            n_tests;
    int            n_fail;
    int            run_len;
    int            max_run;
    int            min_cred;
    logic [DW-1:0] pop_log [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) begin
            w = (w << 32) | DW'($urandom);
        end
        return w;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, DW'(rd_req_ready), DW'(1));
        chk({tag, "_rd_valid"},  DW'(rd_valid),     DW'(0));
        chk({tag, "_rddata"},    rddata,            '0);
        chk({tag, "_credits"},   DW'(credits),      DW'(FD));
        chk({tag, "_err"},       DW'(err_rd_drop),  DW'(0));
    endtask

    // Called at the falling edge: check outputs, advance model, take one edge.
    task automatic tick();
        bit            exp_valid;
        bit            exp_rdy;
        logic [DW-1:0] exp_data;
        exp_valid = (q_data.size() > 0) && (q_time[0] <= cyc);
        exp_data  = exp_valid ? q_data[0] : '0;
        exp_rdy   = (q_data.size() < FD);
        chk("rd_valid",     DW'(rd_valid),     DW'(exp_valid));
        chk("rddata",       rddata,            exp_data);
        chk("credits",      DW'(credits),      DW'(FD - q_data.size()));
        chk("rd_req_ready", DW'(rd_req_ready), DW'(exp_rdy));
        chk("err_rd_drop",  DW'(err_rd_drop),  DW'(err_m));
        run_len = rd_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        if (int'(credits) < min_cred) min_cred = int'(credits);
        if (exp_valid && rd_ready) begin
            pop_log.push_back(rddata);
            void'(q_data.pop_front());
            void'(q_time.pop_front());
        end
        if (rden) begin
            if (exp_rdy) begin
                q_data.push_back(mem_m[rdaddress]);
                q_time.push_back(cyc + 1 + LAT);
            end else begin
                err_m = 1'b1;
            end
        end
        if (wren) begin
            for (int b = 0; b < DW; b++) begin
                if (wr_chmask[b / CW]) mem_m[wraddress][b] = wrdata[b];
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        wren = 1'b0;
        rden = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [DW-1:0] exp_w;
        int            n;
        n_tests = 0; n_fail = 0; cyc = 0; err_m = 1'b0;
        run_len = 0; max_run = 0; min_cred = 99;
        wren = 1'b0; wraddress = '0; wrdata = '0; wr_chmask = '0;
        rden = 1'b0; rdaddress = '0; rd_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2 chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Preload addresses 0..127 with their own address value
        for (int a = 0; a < 128; a++) begin
            wren = 1'b1; wraddress = AW'(a); wrdata = DW'(a); wr_chmask = '1;
            tick();
        end
        wren = 1'b0;
        idle(2);

        // Streaming: 100 back-to-back reads with rd_ready held high
        run_len = 0; max_run = 0; min_cred = 99; pop_log.delete();
        rd_ready = 1'b1;
        for (int a = 0; a < 100; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        idle(LAT + 5);
        chk("stream_run", DW'(max_run), DW'(100));
        chk("stream_min_credits", DW'(min_cred), DW'(FD - LAT - 1));
        chk("stream_count", DW'(pop_log.size()), DW'(100));
        for (int i = 0; i < 100 && i < pop_log.size(); i++) chk("stream_data", pop_log[i], DW'(i));

        // Masked write then latency measurement
        pop_log.delete();
        wren = 1'b1; wraddress = AW'(5); wrdata = '1; wr_chmask = '1;
        tick();
        wrdata = '0; wr_chmask = NCH'(1);
        tick();
        wren = 1'b0; rden = 1'b1; rdaddress = AW'(5);
        tick();
        rden = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("mask_latency", DW'(n), DW'(LAT));
        exp_w = '1;
        exp_w[71:0] = '0;
        chk("mask_data", rddata, exp_w);
        idle(3);

        // Backpressure: 20 reads with the consumer stalled
        pop_log.delete();
        rd_ready = 1'b0;
        for (int a = 10; a < 30; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        rden = 1'b0;
        chk("bp_credits", DW'(credits), DW'(0));
        chk("bp_req_ready", DW'(rd_req_ready), DW'(0));
        chk("bp_err", DW'(err_rd_drop), DW'(1));
        rd_ready = 1'b1;
        idle(LAT + 20);
        chk("bp_count", DW'(pop_log.size()), DW'(16));
        for (int i = 0; i < 16 && i < pop_log.size(); i++) chk("bp_data", pop_log[i], DW'(10 + i));
        chk("bp_credits_back", DW'(credits), DW'(FD));

        // Same-edge read/write collision on address 7
        pop_log.delete();
        wren = 1'b1; wraddress = AW'(7); wrdata = DW'('hA); wr_chmask = '1;
        tick();
        wrdata = DW'('hB); rden = 1'b1; rdaddress = AW'(7);
        tick();
        wren = 1'b0;
        tick();
        idle(LAT + 4);
        chk("coll_count", DW'(pop_log.size()), DW'(2));
        if (pop_log.size() >= 2) begin
            chk("coll_old", pop_log[0], DW'('hA));
            chk("coll_new", pop_log[1], DW'('hB));
        end

        // Simultaneous accept and pop with one credit left
        rd_ready = 1'b0;
        for (int a = 40; a < 55; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        rden = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ap_valid", DW'(rd_valid), DW'(1));
        chk("ap_credits_before", DW'(credits), DW'(1));
        rden = 1'b1; rdaddress = AW'(60); rd_ready = 1'b1;
        tick();
        rden = 1'b0; rd_ready = 1'b0;
        chk("ap_credits_after", DW'(credits), DW'(1));
        chk("ap_req_ready_after", DW'(rd_req_ready), DW'(1));
        rd_ready = 1'b1;
        idle(LAT + 25);

        // Reset with 3 queued and 4 in-flight responses
        rd_ready = 1'b0;
        for (int a = 1; a < 4; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        idle(LAT + 1);
        for (int a = 4; a < 8; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        rden = 1'b0;
        chk("pre_rst_valid", DW'(rd_valid), DW'(1));
        #1 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        q_data.delete();
        q_time.delete();
        err_m = 1'b0;
        rst = 1'b0;
        pop_log.delete();
        rd_ready = 1'b1;
        idle(LAT + 10);
        chk("post_rst_no_resp", DW'(pop_log.size()), DW'(0));
        for (int a = 1; a < 5; a++) begin
            rden = 1'b1; rdaddress = AW'(a);
            tick();
        end
        idle(LAT + 4);
        chk("reread_count", DW'(pop_log.size()), DW'(4));
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("reread_data", pop_log[i], DW'(i + 1));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wren      = ($urandom_range(0, 9) < 3);
            wraddress = AW'($urandom_range(0, 127));
            wrdata    = rand_word();
            wr_chmask = NCH'($urandom);
            rden      = $urandom_range(0, 1) == 1;
            rdaddress = AW'($urandom_range(0, 127));
            rd_ready  = ($urandom_range(0, 9) < 7);
            tick();
        end
        rd_ready = 1'b1;
        idle(LAT + FD + 4);
        chk("final_credits", DW'(credits), DW'(FD));
        chk("final_valid", DW'(rd_valid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_mem_chan.md
# pkt_mem_chan

Parametrised, channel-sliced packet-buffer memory with a fixed, configurable read latency and a credit-protected read-response FIFO. It generalises the single-latency eSRAM/BRAM packet store. A wide word is striped across NCH equal channels with per-channel write masking. Read responses are delivered over a valid/ready handshake, so a stalled consumer never loses data. It sits between the packet writer (parser side) and the packet reader (scheduler/egress side) in the packet-buffer path.

## Interface
- DWIDTH, 520, logical word width
- CH_WIDTH, 72, physical channel width; NCH = ceil(DWIDTH/CH_WIDTH) (8 at defaults)
- AWIDTH, 12, address width; depth = 2**AWIDTH words
- RD_LAT, 12, memory read pipeline depth; integer ≥1
- FIFO_DEPTH, 16, response FIFO entries; power of two ≥2
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- wren  in  1  write strobe
- wraddress  in  AWIDTH  write address
- wrdata  in  DWIDTH  write data
- wr_chmask  in  NCH  per-channel write enable; bit c covers wrdata[c*CH_WIDTH +: CH_WIDTH]
- rden  in  1  read request
- rdaddress  in  AWIDTH  read address
- rd_req_ready  out  1  read request can be accepted (credits ≠ 0)
- rd_valid  out  1  response available at FIFO head
- rd_ready  in  1  consumer takes response
- rddata  out  DWIDTH  response data
- credits  out  $clog2(FIFO_DEPTH)+1  free response slots
- err_rd_drop  out  1  sticky: rden seen while rd_req_ready=0

## Operation
- Channel c stores bits [c*CH_WIDTH +: CH_WIDTH]. The top channel is zero-padded above DWIDTH on write. The padding is discarded on read.
- Write: on a clk edge with wren=1, each channel c with wr_chmask[c]=1 stores its slice at wraddress. Masked channels keep their old contents. wren with an all-zero mask is a no-op.
- Read accept: rden && rd_req_ready at an edge. The address is sampled, credits decrements by 1, and a valid token enters an RD_LAT-stage data/valid pipeline.
- Read-during-write to the same address at the same edge returns OLD data. A read at any later edge returns the new data.
- On pipeline exit, the word is pushed into the response FIFO (show-ahead). rd_valid = FIFO not empty. rddata = head entry, forced to 0 when rd_valid=0.
- Pop: rd_valid && rd_ready at an edge. The head advances and credits increments by 1.
- Accept and pop at the same edge leave credits unchanged.
- Invariant: in-flight + stored + credits = FIFO_DEPTH. The FIFO can never overflow, and no push is ever refused.
- Rejected rden (rd_req_ready=0): the request is dropped, with no credit change and no pipeline token, and err_rd_drop is set to 1. err_rd_drop clears only on rst.
- rst: valid pipeline cleared, FIFO pointers 0, credits = FIFO_DEPTH, err_rd_drop = 0. Memory contents are retained.
- rst asserted mid-operation discards all in-flight and queued responses; no response is ever emitted for pre-reset requests.

## Timing
- Reset values: rd_req_ready=1, rd_valid=0, rddata=0, credits=FIFO_DEPTH, err_rd_drop=0.
- Read latency: request accepted at edge k, FIFO push at edge k+RD_LAT, rd_valid high in the cycle after edge k+RD_LAT. With an empty FIFO, that is RD_LAT+1 cycles after the request cycle.
- Throughput: one accept per cycle, sustained indefinitely while rd_ready=1.
- Credits update at the same edge as accept/pop, so rd_req_ready falls in the cycle after the accept that consumes the last credit.
- Responses are returned in request order.
- Write-to-read visibility: a read accepted at edge w+1 or later sees a write made at edge w.

## Test plan
- Masked write: write addr 5 with all-ones data and mask=all; write addr 5 with 0 and mask=0x01; read addr 5 → rddata = all-ones except bits [71:0]=0, rd_valid exactly RD_LAT+1 cycles after rden.
- Streaming: rd_ready=1, 100 back-to-back reads of addrs 0..99 pre-written with addr value → 100 consecutive rd_valid cycles, data in order, credits never below FIFO_DEPTH−RD_LAT−1.
- Backpressure: rd_ready=0, issue 20 reads → exactly 16 accepted, rd_req_ready=0 with credits=0, err_rd_drop=1. Then release rd_ready → 16 responses in order, credits returns to 16.
- Same-edge collision: wren to addr 7 (old 0xA, new 0xB) with rden addr 7 at the same edge → response 0xA; a read one cycle later → 0xB.
- Simultaneous accept/pop at credits=1 → credits stays 1 and rd_req_ready stays 1.
- Reset mid-flight: 4 reads in flight plus 3 queued, pulse rst asynchronously → outputs at reset values immediately, no rd_valid afterwards, memory data intact on re-read.
